// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-Stream output between two
// image sources, with per-source frame counters, orphan-beat dropping and SOF error flag.
module axis_frame_arbiter #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned NUM_LINES          = 28,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,

  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  input  logic                            s00_axis_tuser,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,

  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                            s01_axis_tlast,
  input  logic                            s01_axis_tuser,
  input  logic                            s01_axis_tvalid,
  output logic                            s01_axis_tready,

  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic                            m00_axis_tuser,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,

  output logic [1:0]                      grant,
  output logic                            frame_done,
  output logic [CNT_WIDTH-1:0]            frames_s00,
  output logic [CNT_WIDTH-1:0]            frames_s01,
  output logic [CNT_WIDTH-1:0]            drop_cnt,
  output logic                            sof_err
);

  localparam int unsigned LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state;
  logic                ptr;
  logic                first_beat;
  logic [LINE_W-1:0]   line;

  logic                idle;
  logic                req0, req1;
  logic                orph0, orph1;
  logic                hs;
  logic [1:0]          drop_n;
  logic [CNT_WIDTH:0]  drop_sum;
  logic [CNT_WIDTH-1:0] drop_next;

  assign idle  = (state == IDLE);
  assign req0  = s00_axis_tvalid & s00_axis_tuser;
  assign req1  = s01_axis_tvalid & s01_axis_tuser;
  assign orph0 = s00_axis_tvalid & ~s00_axis_tuser;
  assign orph1 = s01_axis_tvalid & ~s01_axis_tuser;

  // Zero-latency output mux steered by the registered grant
  always_comb begin
    m00_axis_tdata  = s00_axis_tdata;
    m00_axis_tstrb  = s00_axis_tstrb;
    m00_axis_tlast  = s00_axis_tlast;
    m00_axis_tuser  = s00_axis_tuser;
    if (grant[1]) begin
      m00_axis_tdata = s01_axis_tdata;
      m00_axis_tstrb = s01_axis_tstrb;
      m00_axis_tlast = s01_axis_tlast;
      m00_axis_tuser = s01_axis_tuser;
    end
    m00_axis_tvalid = ~reset & ((grant[0] & s00_axis_tvalid) | (grant[1] & s01_axis_tvalid));
    s00_axis_tready = ~reset & ((grant[0] & m00_axis_tready) | (idle & orph0));
    s01_axis_tready = ~reset & ((grant[1] & m00_axis_tready) | (idle & orph1));
  end

  assign hs = m00_axis_tvalid & m00_axis_tready;

  // Orphan beats are swallowed in IDLE; the counter saturates instead of wrapping
  assign drop_n    = {1'b0, idle & orph0} + {1'b0, idle & orph1};
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_WIDTH + 1)'(drop_n);
  assign drop_next = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      ptr        <= 1'b0;
      first_beat <= 1'b0;
      line       <= '0;
      frame_done <= 1'b0;
      frames_s00 <= '0;
      frames_s01 <= '0;
      drop_cnt   <= '0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          drop_cnt <= drop_next;
          if (enable && (req0 || req1)) begin
            state      <= XFER;
            first_beat <= 1'b1;
            grant      <= (req0 && (!req1 || !ptr)) ? 2'b01 : 2'b10;
          end
        end
        XFER: begin
          if (hs) begin
            first_beat <= 1'b0;
            if (m00_axis_tuser && !first_beat) sof_err <= 1'b1;
            if (m00_axis_tlast) begin
              if (line == LAST_LINE) begin
                // Frame end: release the output and hand priority to the other source
                state      <= IDLE;
                grant      <= 2'b00;
                line       <= '0;
                frame_done <= 1'b1;
                ptr        <= grant[0];
                if (grant[0]) frames_s00 <= frames_s00 + CNT_WIDTH'(1);
                else          frames_s01 <= frames_s01 + CNT_WIDTH'(1);
              end else begin
                line <= line + LINE_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Shares one downstream AXI-Stream image datapath (pass-through / CNN layer input) between two upstream image sources, s00 and s01.
- Arbitrates at whole-frame granularity with round-robin fairness. A frame starts with a tuser beat and ends on the tlast of its NUM_LINES-th line.
- Sits between the image readers / DMA sources and the first processing stage. It also reports per-source frame counts, dropped-beat counts and framing errors.

Parameters:
- C_AXIS_TDATA_WIDTH, 32, data width of all streams; tstrb width is C_AXIS_TDATA_WIDTH/8.
- NUM_LINES, 28, tlast-terminated lines per frame; must be ≥1.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high permits new grants; low blocks new grants but lets the current frame finish.
- s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  source 0 data.
- s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  source 0 byte strobes.
- s00_axis_tlast  in  1  source 0 end of line.
- s00_axis_tuser  in  1  source 0 start of frame.
- s00_axis_tvalid  in  1  source 0 valid.
- s00_axis_tready  out  1  source 0 ready.
- s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast, s01_axis_tuser, s01_axis_tvalid, s01_axis_tready: same widths and directions as s00, for source 1.
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  output data.
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  output strobes.
- m00_axis_tlast  out  1  output end of line.
- m00_axis_tuser  out  1  output start of frame.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tready  in  1  downstream ready.
- grant  out  2  one-hot owner of the output; bit0 = s00, bit1 = s01; 00 when idle.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frames_s00  out  CNT_WIDTH  frames forwarded from s00; wraps.
- frames_s01  out  CNT_WIDTH  frames forwarded from s01; wraps.
- drop_cnt  out  CNT_WIDTH  orphan beats discarded; saturates at all-ones.
- sof_err  out  1  sticky flag: tuser seen on a non-first beat of a granted frame.

Behaviour:
- Reset (synchronous, active-high) puts the block in this state on the next edge:
  - state IDLE; grant=00; every tready=0; m00_axis_tvalid=0.
  - frame_done=0; all counters 0; sof_err=0; line counter 0.
  - round-robin pointer favours s00.
  - Reset mid-frame abandons the frame with no completion pulse.
- State IDLE:
  - Request_i = s0i_axis_tvalid & s0i_axis_tuser.
  - If enable=1 and any request: grant the requester; if both request, grant the one the pointer favours. Go to XFER on the next edge; no beat transfers in the arbitration cycle.
  - A source presenting tvalid=1 with tuser=0 is orphaned. It gets tready=1 in IDLE, its beat is discarded, and drop_cnt increments (+2 when both sources are orphaned in the same cycle).
  - Orphans are not dropped in the cycle that source is granted.
- State XFER:
  - Zero-latency combinational mux. m00 data/strb/last/user/valid = granted source's signals; granted tready = m00_axis_tready.
  - Non-granted tready=0; its beats are held, never dropped.
  - Handshake = m00_axis_tvalid & m00_axis_tready.
  - Line counter increments on each handshake with tlast=1.
  - A handshake with tuser=1, other than the first beat of the frame, sets sof_err. The beat is still forwarded and the line counter is unaffected.
- Frame end = handshake with tlast=1 while line counter = NUM_LINES-1. On that edge:
  - return to IDLE; grant=00; line counter cleared.
  - frame_done pulses for one cycle, in the cycle after the last beat.
  - the granted source's frame counter increments.
  - the pointer moves to the other source.
- Inter-frame gap: last beat at cycle N, IDLE/arbitration at N+1, first beat of the next frame at N+2.
- enable=0 during XFER has no effect until frame end. It then holds IDLE: orphan dropping continues, no grant is made.
- Backpressure (m00_axis_tready=0): outputs mirror the granted source; no state changes.
- frames_s00/s01 wrap at 2^CNT_WIDTH; drop_cnt saturates at all-ones.

Test Plan:
- Single source, NUM_LINES=2, s00 sends a 4-beat frame (tuser on beat 0, tlast on beats 1 and 3), m00_axis_tready=1: m00 mirrors beats 0xA0..0xA3 starting the cycle after the request; frame_done pulses once; frames_s00=1; grant returns to 00.
- Both sources request simultaneously out of reset, each sending two frames: grant order s00, s01, s00, s01; one idle cycle between frames; frames_s00=2, frames_s01=2; no beat lost or reordered.
- s01 sends 3 beats with tuser=0 while idle, then a valid frame: drop_cnt=3; the frame is then forwarded intact.
- m00_axis_tready toggled 1,0,1,0 during XFER: no duplicated or skipped beats; s00_axis_tready tracks m00_axis_tready; s01_axis_tready stays 0.
- tuser=1 on beat 2 of a granted frame: sof_err=1 and stays set; the frame completes after the correct tlast count.
- reset asserted mid-frame: next edge gives grant=00, all counters 0, every tready=0; a fresh frame on s01 after reset is granted s00-favoured but accepted because only s01 requests.
